rotate_scheduler: RTL
=====================

// Module: rotate_scheduler
// PURPOSE
//  Shares one 4-bit left/right rotator (shift step 0..3) between two requesters.
//  Round-robin arbiter plus multi-pass sequencer: amounts above 3 run as repeated passes of at most 3 each.
//  Completed result is held on a valid/ready response port.
//  Sits between the client blocks and the combinational rotator datapath.
// PARAMETERS
//  AMT_W     4   width of the requested rotate amount (0..2^AMT_W-1)
//  STEP_MAX  3   maximum rotate step per pass; fixed by the rotator's 2-bit shamt
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has a job
//  req0_ready   out  1      requester 0 job accepted this cycle
//  req0_data    in   4      operand
//  req0_dir     in   1      0 = rotate left, 1 = rotate right
//  req0_amt     in   AMT_W  rotate amount
//  req1_*       -    -      same set as req0_* for requester 1
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer takes result
//  rsp_data     out  4      rotated operand
//  rsp_id       out  1      index of the requester that owns rsp_data
//  busy         out  1      scheduler not in IDLE
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high.
//  - Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, reqN_ready=0, rr_ptr=0.
//  - FSM states are IDLE, ROT and RESP. busy = (state != IDLE).
//  - IDLE, grant:
//    - reqN_ready is combinational: high only for the granted requester whose valid is high.
//    - Both valid: grant requester rr_ptr. Only one valid: grant that one.
//    - A non-granted requester must hold valid and its payload stable.
//  - IDLE, capture (on handshake): work <= data, dir, rem <= amt, rsp_id <= N.
//    - rem==0: next state RESP. Otherwise: next state ROT.
//  - ROT, per cycle:
//    - step = min(rem, 3).
//    - work <= rotate(work, dir, step); rem <= rem - step.
//    - Go to RESP when rem - step == 0.
//  - Rotate rules:
//    - Left by 1 = {w[2:0], w[3]}; right by 1 = {w[0], w[3:1]}.
//    - A step of k applies k single rotations in one cycle.
//  - Latency: handshake at edge T; rsp_valid is high after edge T + ceil(amt/3) + 1 (amt=0 gives T+1).
//  - RESP:
//    - rsp_valid=1; rsp_data and rsp_id held stable until rsp_ready.
//    - On rsp_valid && rsp_ready: go to IDLE, rr_ptr <= ~rsp_id, rsp_valid <= 0.
//    - No new acceptance in the same cycle as the response handshake.
//  - reqN_ready stays 0 in ROT and RESP; the block holds one job at a time.
//  - Reset mid-job: job discarded, no response; reset values apply after the reset edge.
// CONFIGURATION
//  - ROTATE_SCHED_MOD4_EN defined:
//    - amt is reduced mod 4 at capture (rem <= amt[1:0]).
//    - At most one ROT cycle; amt%4==0 goes straight to RESP.
//    - Result is identical to the non-MOD4 build; only latency changes.
//  - ROTATE_SCHED_MOD4_EN undefined: full multi-pass sequencing as described above.
// TESTING
//  1. req0 data=1001 dir=L amt=1 -> rsp_data=0011, rsp_id=0, rsp_valid high 2 edges after accept.
//  2. req1 data=1011 dir=R amt=5 -> rsp_data=1101.
//     - Without the macro: 2 ROT cycles (step 3 then 2). With ROTATE_SCHED_MOD4_EN: 1 ROT cycle.
//  3. Both valid after reset, amt=2 each -> req0 served first, then req1.
//     - Next simultaneous pair -> req0 first again (rr_ptr=~1).
//  4. req0 data=0110 amt=0 -> rsp_data=0110, rsp_valid 1 edge after accept, no ROT state.
//  5. rsp_ready low 5 cycles in RESP, req1_valid high -> rsp_data/rsp_id stable, req1_ready=0 throughout.
//  6. reset asserted 1 cycle during ROT (amt=9) -> next cycle state=IDLE, all outputs 0.
//     - No response for the aborted job; req0 accepted again afterwards.

Source files
------------

// File: rtl/rotate_scheduler_if.sv
// rotate_scheduler_if
//   Bundles the two requester ports and the response port of rotate_scheduler.
//   master : client/consumer side (drives requests and rsp_ready)
//   slave  : scheduler side (drives reqN_ready and the response)
//   Signals: reqN_valid/ready/data/dir/amt for N = 0,1; rsp_valid/ready/data/id.
interface rotate_scheduler_if #(
    parameter int AMT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_data;
    logic             req0_dir;
    logic [AMT_W-1:0] req0_amt;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_data;
    logic             req1_dir;
    logic [AMT_W-1:0] req1_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_data;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_data, req0_dir, req0_amt,
        output req1_valid, req1_data, req1_dir, req1_amt,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_dir, req0_amt,
        input  req1_valid, req1_data, req1_dir, req1_amt,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/rotate_scheduler.sv
// rotate_scheduler
//   Shares one 4-bit left/right rotator (step 0..3 per pass) between two
//   requesters. Round-robin grant in IDLE, amounts above 3 are worked off as
//   repeated passes, and the result is held on a valid/ready response port.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : rotate_scheduler_if.slave (requests in, response out)
//   busy   : scheduler is not in IDLE
// Configuration
//   ROTATE_SCHED_MOD4_EN : reduce the amount mod 4 at capture, so at most one
//                          rotate pass runs; result unchanged, latency shorter.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; grants and captures a job
// ROT   | applying min(rem,3) rotations per cycle until rem hits 0
// RESP  | result presented; rsp_valid rises one cycle after entry
module rotate_scheduler #(
    parameter int AMT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    rotate_scheduler_if.slave   bus,
    output logic                busy
);
    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {IDLE, ROT, RESP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       work;
    logic             dir;
    logic [AMT_W-1:0] rem;
    logic             rsp_id;
    logic             rsp_valid;
    logic             rr_ptr;

    logic             gnt0, gnt1;
    logic             ready0, ready1;
    logic [AMT_W-1:0] cap_amt;
    logic [AMT_W-1:0] cap_rem;
    logic [1:0]       step;

    function automatic logic [3:0] rotate4(input logic [3:0] w, input logic right,
                                           input logic [1:0] k);
        logic [7:0] dbl;
        dbl = {w, w};
        if (right) begin
            dbl = dbl >> k;
            return dbl[3:0];
        end
        dbl = dbl << k;
        return dbl[7:4];
    endfunction

    always_comb begin
        gnt0    = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
        gnt1    = bus.req1_valid && (!bus.req0_valid || rr_ptr);
        cap_amt = gnt1 ? bus.req1_amt : bus.req0_amt;
`ifdef ROTATE_SCHED_MOD4_EN
        cap_rem = AMT_W'(cap_amt[1:0]);
`else
        cap_rem = cap_amt;
`endif
        step    = (rem > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];
    end

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state)
            IDLE: begin
                ready0 = gnt0;
                ready1 = gnt1;
                if (gnt0 || gnt1)
                    state_nxt = (cap_rem == '0) ? RESP : ROT;
            end
            ROT: begin
                if (rem == AMT_W'(step))
                    state_nxt = RESP;
            end
            RESP: begin
                if (rsp_valid && bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            dir       <= 1'b0;
            rem       <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        work   <= gnt1 ? bus.req1_data : bus.req0_data;
                        dir    <= gnt1 ? bus.req1_dir  : bus.req0_dir;
                        rem    <= cap_rem;
                        rsp_id <= gnt1;
                    end
                end
                ROT: begin
                    work <= rotate4(work, dir, step);
                    rem  <= rem - AMT_W'(step);
                end
                RESP: begin
                    // rsp_valid is registered so it rises one cycle after RESP entry
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = work;
    assign bus.rsp_id     = rsp_id;
    assign busy           = (state != IDLE);
endmodule
